stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter REG_WIDTH, default `REG_WIDTH (32), datapath width; byte-lane count NB = REG_WIDTH/8.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 EX_MEM_valid  input  1  instruction present in EX/MEM.
REQ-005 EX_MEM_alu_out  input  REG_WIDTH  ALU result; byte address for loads/stores.
REQ-006 EX_MEM_rs2_data  input  REG_WIDTH  store data.
REQ-007 EX_MEM_mem_read / EX_MEM_mem_write  input  1 each  load / store; never both set.
REQ-008 EX_MEM_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 EX_MEM_reg_write_en  input  1;  EX_MEM_rd  input  5  destination register.
REQ-010 dmem_req  output  1;  dmem_we  output  1;  dmem_addr  output  REG_WIDTH;  dmem_wdata  output  REG_WIDTH;  dmem_be  output  NB  data-memory request.
REQ-011 dmem_ready  input  1;  dmem_rdata  input  REG_WIDTH  memory completion and read word.
REQ-012 mem_stall  output  1  freeze IF..EX/MEM.
REQ-013 MEM_WB_valid, MEM_WB_reg_write_en, MEM_WB_reg_wb_sel  output  1 each;  MEM_WB_alu_out  output  REG_WIDTH;  MEM_WB_rd  output  5  MEM/WB register.
REQ-014 misalign_exc  output  1  misaligned-access pulse.

Function
REQ-015 FSM states IDLE and ACCESS; IDLE->ACCESS when EX_MEM_valid and (mem_read or mem_write), aligned; ACCESS->IDLE on dmem_ready.
REQ-016 In ACCESS: dmem_req=1; dmem_addr, dmem_we, dmem_wdata, dmem_be held stable until the dmem_ready cycle inclusive.
REQ-017 dmem_addr = EX_MEM_alu_out with the low two bits cleared (word address); dmem_we = mem_write.
REQ-018 Store lanes: SB be=0001<<addr[1:0], wdata = byte replicated x4; SH be=0011<<addr[1:0], halfword replicated x2; SW be=1111, wdata=rs2.
REQ-019 Load extraction from dmem_rdata by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-020 mem_stall = 1 whenever EX_MEM holds an aligned memory op and the current cycle is not ACCESS with dmem_ready=1; otherwise 0 (combinational).
REQ-021 Non-memory op: MEM/WB loaded next edge, latency 1, no stall, MEM_WB_alu_out = EX_MEM_alu_out.
REQ-022 Memory op: MEM/WB loaded on the dmem_ready edge; load -> extracted data, store -> MEM_WB_reg_write_en=0; minimum latency 2 cycles (IDLE + ACCESS with immediate ready).
REQ-023 Each stalled cycle loads a bubble: MEM_WB_valid=0, MEM_WB_reg_write_en=0.
REQ-024 MEM_WB_reg_wb_sel = 1 when the loaded MEM/WB entry is valid and writes a register, else 0.
REQ-025 EX_MEM_valid=0: bubble into MEM/WB, FSM stays IDLE.
REQ-026 dmem_ready while IDLE is ignored.

Reset
REQ-027 reset_n low: FSM->IDLE, dmem_req=0 immediately, all MEM_WB_* outputs 0, misalign_exc=0, mem_stall driven only by EX_MEM inputs.
REQ-028 Reset during ACCESS abandons the access; no MEM/WB write for it; subsequent dmem_ready ignored.

Configuration
REQ-029 Macro RISCV_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 issues no request, pulses misalign_exc for 1 cycle, loads bubble, no stall.
REQ-030 Macro undefined: misalign_exc tied 0; offending low address bits ignored (halfword uses addr[1], word uses 00); access performed normally.

Verification
REQ-031 ADD result 0x0000_1234, rd=5, valid -> next edge MEM_WB_alu_out=0x1234, rd=5, wb_sel=1, no stall.
REQ-032 LB addr 0x103, dmem_rdata 0x80AA_BBCC, ready after 3 ACCESS cycles -> mem_stall 4 cycles, dmem_addr 0x100 stable, MEM_WB_alu_out=0xFFFF_FF80.
REQ-033 SH addr 0x202, rs2 0x0000_BEEF, ready immediate -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, MEM_WB_reg_write_en=0.
REQ-034 LHU addr 0x002, rdata 0x8001_7FFF -> MEM_WB_alu_out=0x0000_8001.
REQ-035 reset_n low during ACCESS then ready pulse -> dmem_req falls asynchronously, MEM_WB_valid stays 0.
REQ-036 LW addr 0x101: with RISCV_MISALIGN_TRAP_EN -> misalign_exc one cycle, dmem_req never 1; without -> dmem_addr 0x100, normal load.

Source files
------------

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem -- MEM pipeline stage with a two-state data-memory access FSM.
//
// Optional feature: define RISCV_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses (no request, one-cycle misalign_exc pulse, bubble).
// Left undefined, misalign_exc is tied 0 and the offending low address bits
// are ignored (halfword uses addr[1], word uses lane 0).
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   EX_MEM_*                  instruction held in the EX/MEM register
//   dmem_req/we/addr/wdata/be data-memory request (valid/ready, see below)
//   dmem_ready, dmem_rdata    memory completion and read word
//   mem_stall                 freezes IF..EX/MEM while a memory op is pending
//   MEM_WB_*                  MEM/WB pipeline register
//   misalign_exc              misaligned-access pulse (trap build only)
//   state_dbg                 FSM state, 0 = IDLE, 1 = ACCESS
//
// Handshake: dmem_req rises in ACCESS and stays high, with addr/we/wdata/be
// stable, up to and including the cycle where dmem_ready is sampled high;
// that cycle completes the transfer. dmem_ready outside ACCESS is ignored.
// -----------------------------------------------------------------------------
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module stage_mem #(
  parameter int REG_WIDTH = `REG_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   EX_MEM_valid,
  input  logic [REG_WIDTH-1:0]   EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]   EX_MEM_rs2_data,
  input  logic                   EX_MEM_mem_read,
  input  logic                   EX_MEM_mem_write,
  input  logic [2:0]             EX_MEM_funct3,
  input  logic                   EX_MEM_reg_write_en,
  input  logic [4:0]             EX_MEM_rd,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [REG_WIDTH-1:0]   dmem_addr,
  output logic [REG_WIDTH-1:0]   dmem_wdata,
  output logic [REG_WIDTH/8-1:0] dmem_be,
  input  logic                   dmem_ready,
  input  logic [REG_WIDTH-1:0]   dmem_rdata,
  output logic                   mem_stall,
  output logic                   MEM_WB_valid,
  output logic                   MEM_WB_reg_write_en,
  output logic                   MEM_WB_reg_wb_sel,
  output logic [REG_WIDTH-1:0]   MEM_WB_alu_out,
  output logic [4:0]             MEM_WB_rd,
  output logic                   misalign_exc,
  output logic                   state_dbg
);

  localparam int NB = REG_WIDTH / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t               state;
  logic [1:0]           acc_off;
  logic [2:0]           acc_funct3;

  logic                 is_mem;
  logic                 misaligned;
  logic                 mem_go;
  logic                 done;
  logic [1:0]           eff_off;
  logic [NB-1:0]        req_be;
  logic [REG_WIDTH-1:0] req_wdata;
  logic [REG_WIDTH-1:0] shifted;
  logic [REG_WIDTH-1:0] load_data;

  assign is_mem    = EX_MEM_valid & (EX_MEM_mem_read | EX_MEM_mem_write);
  assign mem_go    = is_mem & ~misaligned;
  assign done      = (state == ACCESS) & dmem_ready;
  assign mem_stall = mem_go & ~done;
  assign dmem_req  = (state == ACCESS);
  assign state_dbg = state;

`ifdef RISCV_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (EX_MEM_funct3[1:0])
      2'b01:   misaligned = EX_MEM_alu_out[0];
      2'b10:   misaligned = |EX_MEM_alu_out[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_exc <= 1'b0;
    else          misalign_exc <= is_mem & misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  // Effective byte offset: sub-size address bits are dropped, so a trapped
  // access never reaches here and an untrapped one is silently aligned.
  always_comb begin
    case (EX_MEM_funct3[1:0])
      2'b00:   eff_off = EX_MEM_alu_out[1:0];
      2'b01:   eff_off = {EX_MEM_alu_out[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

  always_comb begin
    req_be    = '1;
    req_wdata = EX_MEM_rs2_data;
    case (EX_MEM_funct3[1:0])
      2'b00: begin
        req_be    = NB'(1) << eff_off;
        req_wdata = {NB{EX_MEM_rs2_data[7:0]}};
      end
      2'b01: begin
        req_be    = NB'(3) << eff_off;
        req_wdata = {(NB/2){EX_MEM_rs2_data[15:0]}};
      end
      default: begin
        req_be    = '1;
        req_wdata = EX_MEM_rs2_data;
      end
    endcase
  end

  // Load extraction uses the offset/size latched when the access started.
  assign shifted = dmem_rdata >> {acc_off, 3'b000};

  always_comb begin
    case (acc_funct3)
      3'b000:  load_data = {{(REG_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(REG_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(REG_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(REG_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      dmem_we             <= 1'b0;
      dmem_addr           <= '0;
      dmem_wdata          <= '0;
      dmem_be             <= '0;
      acc_off             <= 2'b00;
      acc_funct3          <= 3'b000;
      MEM_WB_valid        <= 1'b0;
      MEM_WB_reg_write_en <= 1'b0;
      MEM_WB_reg_wb_sel   <= 1'b0;
      MEM_WB_alu_out      <= '0;
      MEM_WB_rd           <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_go) begin
            state      <= ACCESS;
            dmem_we    <= EX_MEM_mem_write;
            dmem_addr  <= {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
            dmem_wdata <= req_wdata;
            dmem_be    <= req_be;
            acc_off    <= eff_off;
            acc_funct3 <= EX_MEM_funct3;
          end
        end
        ACCESS: begin
          if (dmem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (done) begin
        // Completion of the pending memory op; stores never write a register.
        MEM_WB_valid        <= 1'b1;
        MEM_WB_reg_write_en <= EX_MEM_mem_read & EX_MEM_reg_write_en;
        MEM_WB_reg_wb_sel   <= EX_MEM_mem_read & EX_MEM_reg_write_en;
        MEM_WB_alu_out      <= EX_MEM_mem_read ? load_data : EX_MEM_alu_out;
        MEM_WB_rd           <= EX_MEM_rd;
      end else if (EX_MEM_valid & ~EX_MEM_mem_read & ~EX_MEM_mem_write) begin
        MEM_WB_valid        <= 1'b1;
        MEM_WB_reg_write_en <= EX_MEM_reg_write_en;
        MEM_WB_reg_wb_sel   <= EX_MEM_reg_write_en;
        MEM_WB_alu_out      <= EX_MEM_alu_out;
        MEM_WB_rd           <= EX_MEM_rd;
      end else begin
        // Stall, trapped access or empty EX/MEM: insert a bubble.
        MEM_WB_valid        <= 1'b0;
        MEM_WB_reg_write_en <= 1'b0;
        MEM_WB_reg_wb_sel   <= 1'b0;
        MEM_WB_alu_out      <= '0;
        MEM_WB_rd           <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// -----------------------------------------------------------------------------
// tb_stage_mem -- directed, table-driven bench for stage_mem (REG_WIDTH 32).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge or 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_stage_mem;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        EX_MEM_valid = 1'b0;
  logic [31:0] EX_MEM_alu_out = '0;
  logic [31:0] EX_MEM_rs2_data = '0;
  logic        EX_MEM_mem_read = 1'b0;
  logic        EX_MEM_mem_write = 1'b0;
  logic [2:0]  EX_MEM_funct3 = '0;
  logic        EX_MEM_reg_write_en = 1'b0;
  logic [4:0]  EX_MEM_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_stall;
  logic        MEM_WB_valid;
  logic        MEM_WB_reg_write_en;
  logic        MEM_WB_reg_wb_sel;
  logic [31:0] MEM_WB_alu_out;
  logic [4:0]  MEM_WB_rd;
  logic        misalign_exc;
  logic        state_dbg;

  stage_mem dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .EX_MEM_valid        (EX_MEM_valid),
    .EX_MEM_alu_out      (EX_MEM_alu_out),
    .EX_MEM_rs2_data     (EX_MEM_rs2_data),
    .EX_MEM_mem_read     (EX_MEM_mem_read),
    .EX_MEM_mem_write    (EX_MEM_mem_write),
    .EX_MEM_funct3       (EX_MEM_funct3),
    .EX_MEM_reg_write_en (EX_MEM_reg_write_en),
    .EX_MEM_rd           (EX_MEM_rd),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_be             (dmem_be),
    .dmem_ready          (dmem_ready),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .MEM_WB_valid        (MEM_WB_valid),
    .MEM_WB_reg_write_en (MEM_WB_reg_write_en),
    .MEM_WB_reg_wb_sel   (MEM_WB_reg_wb_sel),
    .MEM_WB_alu_out      (MEM_WB_alu_out),
    .MEM_WB_rd           (MEM_WB_rd),
    .misalign_exc        (misalign_exc),
    .state_dbg           (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rwe_in;
    logic [31:0] exp_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rwe;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver ----------------
  task automatic drive_ex(input vec_t v);
    EX_MEM_valid        = 1'b1;
    EX_MEM_mem_read     = v.rd_op;
    EX_MEM_mem_write    = v.wr_op;
    EX_MEM_funct3       = v.f3;
    EX_MEM_alu_out      = v.addr;
    EX_MEM_rs2_data     = v.rs2;
    EX_MEM_rd           = v.rd;
    EX_MEM_reg_write_en = v.rwe_in;
  endtask

  task automatic clear_ex();
    EX_MEM_valid     = 1'b0;
    EX_MEM_mem_read  = 1'b0;
    EX_MEM_mem_write = 1'b0;
    dmem_ready       = 1'b0;
  endtask

  // One operation with immediate dmem_ready; called at posedge+1.
  task automatic do_op(input vec_t v, input string tag);
    logic is_mem;
    is_mem = v.rd_op | v.wr_op;
    drive_ex(v);
    dmem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_stall0"}, {31'd0, mem_stall}, {31'd0, is_mem});
    chk({tag, "_req0"}, {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    if (is_mem) begin
      dmem_ready = 1'b1;
      dmem_rdata = v.rdata;
      @(negedge clk);
      chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, "_stall1"}, {31'd0, mem_stall}, 32'd0);
      chk({tag, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
      chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, v.wr_op});
      chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, v.exp_be});
      if (v.wr_op) chk({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
      @(posedge clk); #1;
    end
    clear_ex();
    chk({tag, "_wb_valid"}, {31'd0, MEM_WB_valid}, 32'd1);
    chk({tag, "_wb_rwe"}, {31'd0, MEM_WB_reg_write_en}, {31'd0, v.exp_rwe});
    chk({tag, "_wb_sel"}, {31'd0, MEM_WB_reg_wb_sel}, {31'd0, v.exp_rwe});
    chk({tag, "_wb_rd"}, {27'd0, MEM_WB_rd}, {27'd0, v.rd});
    chk({tag, "_misalign"}, {31'd0, misalign_exc}, 32'd0);
    if (!v.wr_op) chk({tag, "_wb_out"}, MEM_WB_alu_out, v.exp_out);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    int    stalls;
    int    acc;
    logic  finished;
    logic  addr_bad;
    logic  bubble_bad;
    vec_t  mv;

    //           rd wr f3      addr          rs2           rdata         rd  rwe exp_out       be     wdata         exp_rwe
    vecs[0]  = '{0, 0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        5,  1, 32'h0000_1234, 4'h0, 32'h0,        1}; // ADD
    vecs[1]  = '{0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0,        32'h0,        7,  0, 32'hDEAD_BEEF, 4'h0, 32'h0,        0}; // no rd write
    vecs[2]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,       4,  1, 32'h0,         4'hC, 32'hBEEF_BEEF, 0}; // SH
    vecs[3]  = '{1, 0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 6, 1, 32'h0000_8001, 4'hC, 32'h0,        1}; // LHU
    vecs[4]  = '{1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 8, 1, 32'hFFFF_8001, 4'hC, 32'h0,        1}; // LH neg
    vecs[5]  = '{1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h1234_5678, 10, 1, 32'h0000_0056, 4'h2, 32'h0,       1}; // LB pos
    vecs[6]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 11, 1, 32'h0000_0080, 4'h8, 32'h0,       1}; // LBU
    vecs[7]  = '{1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 12, 1, 32'hCAFE_F00D, 4'hF, 32'h0,       1}; // LW
    vecs[8]  = '{0, 1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0,       13, 1, 32'h0,         4'h2, 32'hA5A5_A5A5, 0}; // SB
    vecs[9]  = '{0, 1, 3'b010, 32'h0000_0404, 32'h0102_0304, 32'h0,       14, 1, 32'h0,         4'hF, 32'h0102_0304, 0}; // SW
    vecs[10] = '{1, 0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_7FFF, 15, 1, 32'h0000_7FFF, 4'h3, 32'h0,       1}; // LH pos

    // Reset state
    #3;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, MEM_WB_valid}, 32'd0);
    chk("rst_wb_rwe", {31'd0, MEM_WB_reg_write_en}, 32'd0);
    chk("rst_wb_sel", {31'd0, MEM_WB_reg_wb_sel}, 32'd0);
    chk("rst_wb_out", MEM_WB_alu_out, 32'd0);
    chk("rst_wb_rd", {27'd0, MEM_WB_rd}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_state", {31'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // LB 0x103 with ready after three ACCESS cycles
    mv = '{1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 9, 1, 32'hFFFF_FF80, 4'h8, 32'h0, 1};
    drive_ex(mv);
    dmem_ready = 1'b0;
    stalls = 0; acc = 0; finished = 1'b0; addr_bad = 1'b0; bubble_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      if (c > 0 && MEM_WB_valid) bubble_bad = 1'b1;
      if (dmem_req) begin
        acc++;
        if (dmem_addr !== 32'h0000_0100 || dmem_be !== 4'h8) addr_bad = 1'b1;
      end
      if (!mem_stall) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (acc == 3) begin
        dmem_ready = 1'b1;
        dmem_rdata = mv.rdata;
      end
    end
    chk("lb_wait_done", {31'd0, finished}, 32'd1);
    @(posedge clk); #1;
    clear_ex();
    chk("lb_wait_stalls", stalls, 32'd4);
    chk("lb_wait_addr_stable", {31'd0, addr_bad}, 32'd0);
    chk("lb_wait_bubbles", {31'd0, bubble_bad}, 32'd0);
    chk("lb_wait_wb_valid", {31'd0, MEM_WB_valid}, 32'd1);
    chk("lb_wait_wb_out", MEM_WB_alu_out, 32'hFFFF_FF80);
    chk("lb_wait_wb_rd", {27'd0, MEM_WB_rd}, 32'd9);

    // Misaligned LW 0x101
    mv = '{1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 3, 1, 32'h1122_3344, 4'hF, 32'h0, 1};
`ifdef RISCV_MISALIGN_TRAP_EN
    drive_ex(mv);
    @(negedge clk);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    chk("mis_req0", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    clear_ex();
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_req1", {31'd0, dmem_req}, 32'd0);
    chk("mis_wb_valid", {31'd0, MEM_WB_valid}, 32'd0);
    @(posedge clk); #1;
    chk("mis_exc_pulse", {31'd0, misalign_exc}, 32'd0);
    chk("mis_req2", {31'd0, dmem_req}, 32'd0);
`else
    do_op(mv, "mis_lw");
`endif

    // Reset during ACCESS, then a ready pulse
    mv = '{1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 2, 1, 32'h0, 4'hF, 32'h0, 1};
    drive_ex(mv);
    @(posedge clk); #1;
    chk("rsta_req_before", {31'd0, dmem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rsta_req_async", {31'd0, dmem_req}, 32'd0);
    chk("rsta_state", {31'd0, state_dbg}, 32'd0);
    chk("rsta_stall_ex", {31'd0, mem_stall}, 32'd1);
    EX_MEM_valid = 1'b0;
    dmem_ready   = 1'b1;
    dmem_rdata   = mv.rdata;
    @(posedge clk); #1;
    chk("rsta_wb_valid0", {31'd0, MEM_WB_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rsta_wb_valid1", {31'd0, MEM_WB_valid}, 32'd0);
    chk("rsta_req_after", {31'd0, dmem_req}, 32'd0);
    clear_ex();

    // Bubble from an empty EX/MEM, with a stray dmem_ready in IDLE
    do_op(vecs[0], "pre_bubble");
    EX_MEM_valid = 1'b0;
    dmem_ready   = 1'b1;
    @(negedge clk);
    chk("idle_ready_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("idle_ready_req", {31'd0, dmem_req}, 32'd0);
    chk("idle_ready_state", {31'd0, state_dbg}, 32'd0);
    chk("bubble_wb_valid", {31'd0, MEM_WB_valid}, 32'd0);
    chk("bubble_wb_rwe", {31'd0, MEM_WB_reg_write_en}, 32'd0);
    chk("bubble_wb_sel", {31'd0, MEM_WB_reg_wb_sel}, 32'd0);
    clear_ex();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
